// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: loads/stores over a req/ack data port with lane
// steering, load extension, alignment checking and a bounded wait for the acknowledge.
//
// state  | meaning
// IDLE   | no access in flight; a valid aligned op stalls and launches an access
// ACCESS | mem_req held with stable we/be/wdata, waiting for mem_ack or timeout
// DONE   | access finished; result/bus_err presented, stage released for one cycle
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [14:0] ctrl_msg,
  input  logic [31:0] alu,
  input  logic [31:0] B,
  output logic [31:0] instruction_out,
  output logic [14:0] ctrl_msg_out,
  output logic [31:0] result,
  output logic        stall,
  output logic        align_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        bus_err_q, bus_err_d;
  logic [15:0] wait_q, wait_d;

  logic        mem_read, mem_write, load_signed;
  logic [1:0]  size, lane;
  logic        op, is_write, align_ok, op_ok, op_err;
  logic [3:0]  be_pat;
  logic [31:0] wdata_pat;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign mem_read    = ctrl_msg[0];
  assign mem_write   = ctrl_msg[1];
  assign size        = ctrl_msg[3:2];
  assign load_signed = ctrl_msg[4];
  assign lane        = alu[1:0];

  // A read+write combination is treated as a plain read.
  assign op       = mem_read | mem_write;
  assign is_write = mem_write & ~mem_read;

  always_comb begin
    align_ok = 1'b0;
    case (size)
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~alu[0];
      2'b10:   align_ok = (alu[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  assign op_ok  = op & align_ok;
  assign op_err = op & ~align_ok;

  always_comb begin
    be_pat    = 4'b1111;
    wdata_pat = B;
    case (size)
      2'b00: begin
        be_pat    = 4'b0001 << lane;
        wdata_pat = {4{B[7:0]}};
      end
      2'b01: begin
        be_pat    = alu[1] ? 4'b1100 : 4'b0011;
        wdata_pat = {2{B[15:0]}};
      end
      default: begin
        be_pat    = 4'b1111;
        wdata_pat = B;
      end
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lane)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
  end

  assign half_sel = alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_data = mem_rdata;
    case (size)
      2'b00:   load_data = {{24{load_signed & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{load_signed & half_sel[15]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bus_err_q <= bus_err_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bus_err_d = bus_err_q;
    wait_d    = wait_q;
    case (state_q)
      S_IDLE: begin
        if (op_ok) begin
          state_d = S_ACCESS;
          wait_d  = '0;
        end
      end
      S_ACCESS: begin
        // An acknowledge in the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          data_d  = load_data;
          state_d = S_DONE;
        end else if (wait_q == TIMEOUT_M1) begin
          bus_err_d = 1'b1;
          data_d    = '0;
          state_d   = S_DONE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        bus_err_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instruction_out = instruction;
    ctrl_msg_out    = ctrl_msg;
    mem_addr        = {alu[31:2], 2'b00};
    mem_wdata       = wdata_pat;
    mem_req         = (state_q == S_ACCESS);
    mem_we          = (state_q == S_ACCESS) & is_write;
    mem_be          = (state_q == S_ACCESS) ? be_pat : 4'b0000;
    // The IDLE-cycle stall is combinational from the inputs, so reset gates it.
    stall           = rst_n & (((state_q == S_IDLE) & op_ok) | (state_q == S_ACCESS));
    align_err       = op_err;
    bus_err         = (state_q == S_DONE) & bus_err_q;
    result          = op_err ? 32'h0 : alu;
    if (state_q == S_DONE) begin
      result = mem_read ? data_q : alu;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stimulus pushes expectations, a monitor
// pops and compares them when each instruction leaves the stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic [14:0] ctrl_msg = '0;
  logic [31:0] alu = '0;
  logic [31:0] b_in = '0;
  logic [31:0] instruction_out;
  logic [14:0] ctrl_msg_out;
  logic [31:0] result;
  logic        stall, align_err, bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instruction(instruction), .ctrl_msg(ctrl_msg), .alu(alu), .B(b_in),
    .instruction_out(instruction_out), .ctrl_msg_out(ctrl_msg_out),
    .result(result), .stall(stall), .align_err(align_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [14:0] ctrl;
    logic [31:0] result;
    logic        align_err;
    logic        bus_err;
    int          stall_cyc;
    int          req_cyc;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        tb_valid = 1'b0;
  int          ack_delay = 0;
  logic [31:0] rd_val = '0;

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  // Memory responder: pulses mem_ack after ack_delay waiting cycles of mem_req.
  initial begin
    int w;
    w = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (w == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_val;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'h0BAD0BAD;
        end
        w++;
      end else begin
        w         = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0BAD0BAD;
      end
    end
  end

  // Monitor: an instruction retires on a cycle with stall low.
  initial begin
    exp_t e;
    int   scnt, rcnt;
    scnt = 0;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        scnt = 0;
        rcnt = 0;
      end else if (tb_valid && q.size() > 0) begin
        e = q[0];
        if (e.req_cyc == 0) begin
          chk(e.tag, "mem_req_idle", {31'b0, mem_req}, 32'h0);
        end else if (mem_req) begin
          rcnt++;
          chk(e.tag, "mem_addr", mem_addr, e.addr);
          chk(e.tag, "mem_be", {28'b0, mem_be}, {28'b0, e.be});
          chk(e.tag, "mem_we", {31'b0, mem_we}, {31'b0, e.we});
          if (e.we) chk(e.tag, "mem_wdata", mem_wdata, e.wdata);
        end
        if (stall) begin
          scnt++;
        end else begin
          void'(q.pop_front());
          chk(e.tag, "result", result, e.result);
          chk(e.tag, "align_err", {31'b0, align_err}, {31'b0, e.align_err});
          chk(e.tag, "bus_err", {31'b0, bus_err}, {31'b0, e.bus_err});
          chk(e.tag, "stall_cycles", 32'(scnt), 32'(e.stall_cyc));
          chk(e.tag, "req_cycles", 32'(rcnt), 32'(e.req_cyc));
          chk(e.tag, "instruction_out", instruction_out, e.instr);
          chk(e.tag, "ctrl_msg_out", {17'b0, ctrl_msg_out}, {17'b0, e.ctrl});
          scnt = 0;
          rcnt = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the instruction retires.
  task automatic issue(input string tag, input logic [14:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] rd, input int dly,
                       input logic [31:0] res, input logic ae, input logic berr,
                       input int sc, input int rc, input logic we,
                       input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    bit   done;
    e.tag = tag; e.instr = {16'hC0DE, a[15:0]}; e.ctrl = c; e.result = res;
    e.align_err = ae; e.bus_err = berr; e.stall_cyc = sc; e.req_cyc = rc;
    e.we = we; e.be = be; e.addr = {a[31:2], 2'b00}; e.wdata = wd;
    q.push_back(e);
    instruction = e.instr;
    ctrl_msg    = c;
    alu         = a;
    b_in        = b;
    rd_val      = rd;
    ack_delay   = dly;
    tb_valid    = 1'b1;
    done        = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s.timeout: stall still %b after 40 cycles, expected release", tag, stall);
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
    ctrl_msg = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Valid aligned load presented while reset is held: outputs must stay quiet.
    ctrl_msg = 15'h0009;
    alu      = 32'h100;
    #3;
    chk("reset", "stall", {31'b0, stall}, 32'h0);
    chk("reset", "mem_req", {31'b0, mem_req}, 32'h0);
    chk("reset", "mem_we", {31'b0, mem_we}, 32'h0);
    chk("reset", "mem_be", {28'b0, mem_be}, 32'h0);
    ctrl_msg = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //    tag          ctrl     alu           B             rdata         dly   result        ae berr st rq we be       wdata
    issue("nop",       15'h000, 32'h12345678, 32'h0,        32'h0,        0,    32'h12345678, 0, 0,   0, 0, 0, 4'b0000, 32'h0);
    issue("ld_word",   15'h009, 32'h100,      32'h0,        32'hDEADBEEF, 2,    32'hDEADBEEF, 0, 0,   4, 3, 0, 4'b1111, 32'h0);
    issue("ld_sbyte",  15'h011, 32'h203,      32'h0,        32'h80112233, 0,    32'hFFFFFF80, 0, 0,   2, 1, 0, 4'b1000, 32'h0);
    issue("ld_ubyte",  15'h001, 32'h203,      32'h0,        32'h80112233, 0,    32'h00000080, 0, 0,   2, 1, 0, 4'b1000, 32'h0);
    issue("st_half",   15'h006, 32'h302,      32'h0000ABCD, 32'h0,        1,    32'h302,      0, 0,   3, 2, 1, 4'b1100, 32'hABCDABCD);
    issue("misalign",  15'h009, 32'h401,      32'h0,        32'h0,        0,    32'h0,        1, 0,   0, 0, 0, 4'b0000, 32'h0);
    issue("bus_tmo",   15'h009, 32'h100,      32'h0,        32'h11111111, 1000, 32'h0,        0, 1,   5, 4, 0, 4'b1111, 32'h0);
    issue("ack_last",  15'h009, 32'h104,      32'h0,        32'h01020304, 3,    32'h01020304, 0, 0,   5, 4, 0, 4'b1111, 32'h0);
    issue("ld_shalf",  15'h015, 32'h502,      32'h0,        32'h80017FFF, 0,    32'hFFFF8001, 0, 0,   2, 1, 0, 4'b1100, 32'h0);
    issue("st_byte",   15'h002, 32'h601,      32'h000000A5, 32'h0,        0,    32'h601,      0, 0,   2, 1, 1, 4'b0010, 32'hA5A5A5A5);
    issue("rsvd_size", 15'h00D, 32'h700,      32'h0,        32'h0,        0,    32'h0,        1, 0,   0, 0, 0, 4'b0000, 32'h0);
    issue("rd_and_wr", 15'h00B, 32'h800,      32'h12345678, 32'hCAFEF00D, 0,    32'hCAFEF00D, 0, 0,   2, 1, 0, 4'b1111, 32'h0);
    issue("ld_uhalf",  15'h005, 32'h900,      32'h0,        32'h12349876, 0,    32'h00009876, 0, 0,   2, 1, 0, 4'b0011, 32'h0);

    // Reset in the middle of an access that never gets acknowledged.
    ctrl_msg  = 15'h009;
    alu       = 32'h100;
    ack_delay = 1000;
    @(posedge clk);
    #1;
    chk("rst_mid", "req_before", {31'b0, mem_req}, 32'h1);
    chk("rst_mid", "stall_before", {31'b0, stall}, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", "req_after", {31'b0, mem_req}, 32'h0);
    chk("rst_mid", "stall_after", {31'b0, stall}, 32'h0);
    chk("rst_mid", "be_after", {28'b0, mem_be}, 32'h0);
    ctrl_msg = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue("post_rst",  15'h009, 32'h100,      32'h0,        32'h55AA55AA, 0,    32'h55AA55AA, 0, 0,   2, 1, 0, 4'b1111, 32'h0);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
